serial_subtractor: RTL

- Bit-serial W-bit subtractor that computes diff = a - b (plus borrow-in when enabled), one bit per clock, LSB first.
- Instantiates one full-subtractor cell and holds the inter-bit borrow in a flip-flop.
- Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.
- Trades area for latency compared with the combinational subtractor.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_if.sv | 34 +++
 rtl/serial_subtractor_fs_cell.sv | 14 +
 rtl/serial_subtractor.sv | 97 +++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding, the legal WIDTH range and the one-bit borrow equation.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Borrow out of a - b - bin for a single bit position.
    function automatic logic borrow_next(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The borrow_in line exists only when SERIAL_SUB_BORROW_IN_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BORROW_IN_EN
    logic             borrow_in;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
`ifdef SERIAL_SUB_BORROW_IN_EN
        output borrow_in,
`endif
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow
    );

    modport slave (
`ifdef SERIAL_SUB_BORROW_IN_EN
        input  borrow_in,
`endif
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out of this position.
// Purely combinational; the only arithmetic cell in the serial datapath.
module fs_cell
    import sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = borrow_next(a, b, bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock via a single fs_cell.
// Optional macro SERIAL_SUB_BORROW_IN_EN adds a borrow_in input loaded on acceptance.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_b_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, a_msb_q, b_msb_q, borrow_q, ovf_q;
    logic             accept, last_bit, d_bit, br_next, br_init;

    assign accept   = bus.in_valid && (state_q == IDLE);
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign br_init = bus.borrow_in;
`else
    assign br_init = 1'b0;
`endif

    fs_cell u_fs_cell (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (br_next)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = SHIFT;
            SHIFT:   if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state_q == IDLE);
        bus.out_valid  = (state_q == DONE);
        bus.diff       = diff_q;
        bus.borrow_out = borrow_q;
        bus.overflow   = ovf_q;
    end

    // NOTE: every datapath register is reset, so an abort leaves no stale partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            sh_a_q  <= bus.a;
            sh_b_q  <= bus.b;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
            cnt_q   <= '0;
            br_q    <= br_init;
        end else if (state_q == SHIFT) begin
            sh_a_q <= sh_a_q >> 1;
            sh_b_q <= sh_b_q >> 1;
            res_q  <= {d_bit, res_q[WIDTH-1:1]};
            br_q   <= br_next;
            // Counter parks at LAST so it never wraps ahead of the DONE transition.
            if (!last_bit) cnt_q <= cnt_q + CW'(1);
            if (last_bit) begin
                diff_q   <= {d_bit, res_q[WIDTH-1:1]};
                borrow_q <= br_next;
                ovf_q    <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
            end
        end
    end
endmodule
